// File: rtl/enc_pkg.sv
// Shared types and widths for the sequential 8-to-3 encoder and its helpers.
package enc_pkg;

  localparam int VEC_W  = 8;
  localparam int CODE_W = 3;

  // IDLE: no vector held. EMIT: pending holds the set bits still to be emitted.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder with selectable direction.
// idx is the lowest set bit when lsb_first=1, else the highest.
// found flags a non-zero vector; single flags exactly one bit set.
module prio_enc8
  import enc_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  input  logic              lsb_first,
  output logic [CODE_W-1:0] idx,
  output logic              found,
  output logic              single
);

  // Scan order is chosen so the last match seen is the winning bit.
  always_comb begin
    idx = '0;
    if (lsb_first) begin
      for (int k = VEC_W - 1; k >= 0; k--) begin
        if (vec[k]) idx = CODE_W'(k);
      end
    end else begin
      for (int k = 0; k < VEC_W; k++) begin
        if (vec[k]) idx = CODE_W'(k);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when one bit was set.
  always_comb begin
    found  = |vec;
    single = found && ((vec & (vec - VEC_W'(1))) == '0);
  end

endmodule

// File: rtl/enc8x3_seq.sv
// Sequential 8-to-3 encoder: accepts a request vector and emits the index of
// each set bit, one code per beat, in priority order.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready depends only on registered state and en; out_valid,
// out_code and out_last depend only on registered state, so once out_valid is
// raised the beat is held unchanged until out_ready takes it.
module enc8x3_seq
  import enc_pkg::*;
#(
  parameter int LSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              zero_err
);

  state_t             state;
  logic [VEC_W-1:0]   pending;
  logic [CODE_W-1:0]  pe_idx;
  logic               pe_found;
  logic               pe_single;
  logic [VEC_W-1:0]   clr_mask;
  logic               emit_active;

  prio_enc8 u_prio (
    .vec       (pending),
    .lsb_first (LSB_FIRST != 0),
    .idx       (pe_idx),
    .found     (pe_found),
    .single    (pe_single)
  );

  // Outputs come only from state and pending; code is forced to 0 when idle.
  always_comb begin
    emit_active = (state == EMIT) && pe_found;
    in_ready    = (state == IDLE) && en;
    out_valid   = emit_active;
    out_code    = emit_active ? pe_idx : '0;
    out_last    = emit_active && pe_single;
    clr_mask    = VEC_W'(1) << pe_idx;
  end

  // FSM, pending register and the one-cycle zero-vector pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pending  <= '0;
      zero_err <= 1'b0;
    end else begin
      zero_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (in_vec != '0) begin
              pending <= in_vec;
              state   <= EMIT;
            end else begin
              zero_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            pending <= pending & ~clr_mask;
            if (pe_single) state <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc8x3_seq.sv
// Directed bench for enc8x3_seq: instance a uses LSB_FIRST=1, instance b uses
// LSB_FIRST=0. Inputs change on the falling edge; outputs are checked there.
module tb_enc8x3_seq;

  logic       clk;
  logic       rst;

  logic       a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_vec;
  logic [2:0] a_out_code;
  logic       a_out_last, a_zero_err;

  logic       b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_vec;
  logic [2:0] b_out_code;
  logic       b_out_last, b_zero_err;

  int tests;
  int fails;
  int beats_a;

  enc8x3_seq #(.LSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vec(a_in_vec), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_code(a_out_code), .out_last(a_out_last), .zero_err(a_zero_err)
  );

  enc8x3_seq #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vec(b_in_vec), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .out_last(b_out_last), .zero_err(b_zero_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // count accepted output beats on instance a
  always @(posedge clk) begin
    if (!rst && a_out_valid && a_out_ready) beats_a = beats_a + 1;
  end

  // reference 3x8 decoder
  function automatic logic [7:0] dec3x8(input logic [2:0] code, input logic en);
    logic [7:0] one;
    one = 8'h01;
    return en ? (one << code) : 8'h00;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a_en = 1'b1; a_in_valid = 1'b1; a_in_vec = 8'hFF; a_out_ready = 1'b1;
    b_en = 1'b1; b_in_valid = 1'b1; b_in_vec = 8'hFF; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({a_out_valid, a_out_code, a_out_last, a_zero_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_a_outputs: got v=%b c=%0d l=%b z=%b want all 0",
               a_out_valid, a_out_code, a_out_last, a_zero_err);
    end
    tests++;
    if ({b_out_valid, b_out_code} !== 4'b0) begin
      fails++;
      $display("FAIL reset_b_outputs: got v=%b c=%0d want 0 0", b_out_valid, b_out_code);
    end
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_in_ready, a_out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0",
               a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_lsb_first();
    logic [2:0] exp_code [3];
    logic       exp_last [3];
    exp_code[0] = 3'd2; exp_code[1] = 3'd5; exp_code[2] = 3'd7;
    exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1;
    a_out_ready = 1'b1; a_in_vec = 8'b1010_0100; a_in_valid = 1'b1;
    tests++;
    if (a_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL lsb_in_ready: got %b want 1", a_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_out_code, a_out_last} !== {1'b1, exp_code[i], exp_last[i]}) begin
        fails++;
        $display("FAIL lsb_beat%0d: got v=%b c=%0d l=%b want v=1 c=%0d l=%b",
                 i, a_out_valid, a_out_code, a_out_last, exp_code[i], exp_last[i]);
      end
    end
    @(negedge clk);
    tests++;
    if ({a_out_valid, a_out_code, a_in_ready} !== 5'b0_000_1) begin
      fails++;
      $display("FAIL lsb_done: got v=%b c=%0d in_ready=%b want 0 0 1",
               a_out_valid, a_out_code, a_in_ready);
    end
  endtask

  task automatic test_backpressure();
    int start;
    start = beats_a;
    a_out_ready = 1'b0; a_in_vec = 8'h12; a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_out_code, a_out_last} !== {1'b1, 3'd1, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b c=%0d l=%b want v=1 c=1 l=0",
                 i, a_out_valid, a_out_code, a_out_last);
      end
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_out_valid, a_out_code, a_out_last} !== {1'b1, 3'd4, 1'b1}) begin
      fails++;
      $display("FAIL bp_second: got v=%b c=%0d l=%b want v=1 c=4 l=1",
               a_out_valid, a_out_code, a_out_last);
    end
    @(negedge clk);
    tests++;
    if (beats_a - start !== 2 || a_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_beats: got beats=%0d v=%b want beats=2 v=0",
               beats_a - start, a_out_valid);
    end
  endtask

  task automatic test_zero_and_enable();
    a_in_vec = 8'h00; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    tests++;
    if ({a_zero_err, a_out_valid, a_in_ready} !== 3'b101) begin
      fails++;
      $display("FAIL zero_pulse: got z=%b v=%b in_ready=%b want 1 0 1",
               a_zero_err, a_out_valid, a_in_ready);
    end
    @(negedge clk);
    tests++;
    if ({a_zero_err, a_out_valid} !== 2'b00) begin
      fails++;
      $display("FAIL zero_one_cycle: got z=%b v=%b want 0 0", a_zero_err, a_out_valid);
    end
    a_en = 1'b0; a_in_vec = 8'h55; a_in_valid = 1'b1;
    #1;
    tests++;
    if (a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL en_low_ready: got %b want 0", a_in_ready);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({a_out_valid, a_zero_err, a_out_code} !== 5'b0) begin
      fails++;
      $display("FAIL en_low_accept: got v=%b z=%b c=%0d want 0 0 0",
               a_out_valid, a_zero_err, a_out_code);
    end
    a_in_valid = 1'b0; a_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_msb_first_roundtrip();
    logic [7:0] acc;
    logic [2:0] exp_code [2];
    logic       exp_last [2];
    exp_code[0] = 3'd7; exp_code[1] = 3'd0;
    exp_last[0] = 1'b0; exp_last[1] = 1'b1;
    acc = 8'h00;
    b_out_ready = 1'b1; b_in_vec = 8'h81; b_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      tests++;
      if ({b_out_valid, b_out_code, b_out_last} !== {1'b1, exp_code[i], exp_last[i]}) begin
        fails++;
        $display("FAIL msb_beat%0d: got v=%b c=%0d l=%b want v=1 c=%0d l=%b",
                 i, b_out_valid, b_out_code, b_out_last, exp_code[i], exp_last[i]);
      end
      if (b_out_valid) acc = acc | dec3x8(b_out_code, 1'b1);
    end
    @(negedge clk);
    tests++;
    if (acc !== 8'h81 || b_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL msb_roundtrip: got or=%h v=%b want 81 0", acc, b_out_valid);
    end
  endtask

  task automatic test_async_reset_midstream();
    int start;
    a_out_ready = 1'b1; a_in_vec = 8'hFF; a_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      tests++;
      if ({a_out_valid, a_out_code} !== {1'b1, 3'(i)}) begin
        fails++;
        $display("FAIL ff_beat%0d: got v=%b c=%0d want v=1 c=%0d",
                 i, a_out_valid, a_out_code, i);
      end
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({a_out_valid, a_out_code, a_out_last} !== 5'b0) begin
      fails++;
      $display("FAIL async_reset: got v=%b c=%0d l=%b want 0 0 0",
               a_out_valid, a_out_code, a_out_last);
    end
    @(negedge clk);
    rst = 1'b0;
    start = beats_a;
    @(negedge clk);
    tests++;
    if ({a_out_valid, a_in_ready} !== 2'b01 || beats_a !== start) begin
      fails++;
      $display("FAIL post_reset_idle: got v=%b in_ready=%b beats=%0d want 0 1 0",
               a_out_valid, a_in_ready, beats_a - start);
    end
    a_in_vec = 8'h08; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    tests++;
    if ({a_out_valid, a_out_code, a_out_last} !== {1'b1, 3'd3, 1'b1}) begin
      fails++;
      $display("FAIL single_beat: got v=%b c=%0d l=%b want v=1 c=3 l=1",
               a_out_valid, a_out_code, a_out_last);
    end
    @(negedge clk);
    tests++;
    if (a_out_valid !== 1'b0 || beats_a - start !== 1) begin
      fails++;
      $display("FAIL single_done: got v=%b beats=%0d want 0 1",
               a_out_valid, beats_a - start);
    end
  endtask

  initial begin
    tests = 0; fails = 0; beats_a = 0;
    test_reset();
    test_lsb_first();
    test_backpressure();
    test_zero_and_enable();
    test_msb_first_roundtrip();
    test_async_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
